// File: rtl/mux8x1_rr_arbiter.sv
// Round-robin arbiter that owns the enable/select of a shared 8x1 mux, with break-before-make between owners.
// Optional hold-time limit: define MUX_ARB_TIMEOUT_EN to revoke a grant after MAX_HOLD cycles.
module mux8x1_rr_arbiter #(
    parameter int N_REQ    = 8,
    parameter int SEL_W    = 4,
    parameter int MAX_HOLD = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic             done,
    output logic [N_REQ-1:0] grant,
    output logic [SEL_W-1:0] sel,
    output logic             mux_en,
    output logic             busy,
    output logic             timeout
);
    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] GRANT = 1'b1;

    logic [0:0]  state_reg;
    logic [2:0]  ptr_reg;
    logic [2:0]  sel_reg;
    logic [15:0] req_dbl;
    logic [7:0]  req_rot;
    logic [2:0]  pick_off;
    logic [2:0]  pick_idx;
    logic        owner_drop;
    logic        force_rel;

    // Rotate so that bit 0 of req_rot is the requester currently holding top priority.
    assign req_dbl = {req, req};
    assign req_rot = req_dbl[7:0] >> ptr_reg | req_dbl[15:8] << (4'd8 - {1'b0, ptr_reg});

    always_comb begin
        pick_off = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (req_rot[i]) pick_off = 3'(i);
        end
    end
    assign pick_idx = ptr_reg + pick_off;

    assign owner_drop = !req[sel_reg] || done;

`ifdef MUX_ARB_TIMEOUT_EN
    logic [3:0] hold_cnt_reg;
    logic       timeout_reg;

    assign force_rel = (hold_cnt_reg == 4'(MAX_HOLD - 1));
    assign timeout   = timeout_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_cnt_reg <= 4'd0;
            timeout_reg  <= 1'b0;
        end else begin
            timeout_reg <= 1'b0;
            if (state_reg == IDLE) begin
                hold_cnt_reg <= 4'd0;
            end else if (!owner_drop) begin
                // A normal release always wins over a forced one, so timeout only fires alone.
                if (force_rel) timeout_reg <= 1'b1;
                else           hold_cnt_reg <= hold_cnt_reg + 4'd1;
            end
        end
    end
`else
    assign force_rel = 1'b0;
    assign timeout   = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            ptr_reg   <= 3'd0;
            sel_reg   <= 3'd0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (req != '0) begin
                        sel_reg   <= pick_idx;
                        state_reg <= GRANT;
                    end
                end
                default: begin
                    if (owner_drop || force_rel) begin
                        state_reg <= IDLE;
                        ptr_reg   <= sel_reg + 3'd1;
                    end
                end
            endcase
        end
    end

    assign busy   = (state_reg == GRANT);
    assign mux_en = busy;
    assign sel    = {{(SEL_W - 3){1'b0}}, sel_reg};

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_grant
            assign grant[gi] = busy && (sel_reg == 3'(gi));
        end
    endgenerate
endmodule

// File: tb/tb_mux8x1_rr_arbiter.sv
// Self-checking bench for mux8x1_rr_arbiter: directed scenarios plus randomized traffic against a behavioural model.
// Honours MUX_ARB_TIMEOUT_EN the same way as the design.
module tb_mux8x1_rr_arbiter;
    localparam int MAX_HOLD = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] req = 8'h00;
    logic       done = 1'b0;
    logic [7:0] grant;
    logic [3:0] sel;
    logic       mux_en;
    logic       busy;
    logic       timeout;

    int n_checks = 0;
    int n_fail   = 0;

    mux8x1_rr_arbiter #(.N_REQ(8), .SEL_W(4), .MAX_HOLD(MAX_HOLD)) dut (
        .clk(clk), .rst(rst), .req(req), .done(done),
        .grant(grant), .sel(sel), .mux_en(mux_en), .busy(busy), .timeout(timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: who owns the mux, who is next in line, how long the owner has held it.
    int  m_owner = -1;
    int  m_ptr   = 0;
    int  m_sel   = 0;
    int  m_held  = 0;
    bit  m_to    = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_owner = -1; m_ptr = 0; m_sel = 0; m_held = 0; m_to = 1'b0;
        end else begin
            m_to = 1'b0;
            if (m_owner < 0) begin
                for (int k = 0; k < 8; k++) begin
                    if (m_owner < 0 && req[(m_ptr + k) % 8]) begin
                        m_owner = (m_ptr + k) % 8;
                        m_sel   = m_owner;
                        m_held  = 1;
                    end
                end
            end else if (!req[m_owner] || done) begin
                m_ptr = (m_owner + 1) % 8; m_owner = -1;
`ifdef MUX_ARB_TIMEOUT_EN
            end else if (m_held >= MAX_HOLD) begin
                m_ptr = (m_owner + 1) % 8; m_owner = -1; m_to = 1'b1;
`endif
            end else begin
                m_held++;
            end
        end
    end

    always @(negedge clk) begin
        logic [7:0] g_exp;
        g_exp = (m_owner < 0) ? 8'h00 : (8'h01 << m_owner);
        chk("model_grant", 32'(grant), 32'(g_exp));
        chk("model_sel", 32'(sel), 32'(m_sel));
        chk("model_mux_en", 32'(mux_en), 32'(m_owner >= 0));
        chk("model_busy", 32'(busy), 32'(m_owner >= 0));
        chk("model_timeout", 32'(timeout), 32'(m_to));
        chk("grant_onehot0", 32'($onehot0(grant)), 32'd1);
    end

    task automatic step();
        @(negedge clk); #1;
    endtask

    task automatic do_reset();
        #1 rst = 1'b1; #1 rst = 1'b0;
    endtask

    initial begin
        int cnt;
        // Reset with all requests pending
        req = 8'hFF;
        step(); step();
        chk("rst_grant", 32'(grant), 32'h0);
        chk("rst_mux_en", 32'(mux_en), 32'h0);
        chk("rst_sel", 32'(sel), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        rst = 1'b0;
        step();
        chk("first_grant", 32'(grant), 32'h01);
        chk("first_sel", 32'(sel), 32'h0);
        chk("first_mux_en", 32'(mux_en), 32'h1);

        // Rotation 1..7,0 with one idle cycle between owners
        done = 1'b1;
        for (int o = 1; o <= 8; o++) begin
            step();
            chk("rot_gap_mux_en", 32'(mux_en), 32'h0);
            step();
            chk("rot_grant", 32'(grant), 32'h1 << (o % 8));
        end

        // Priority after release and pointer wrap
        done = 1'b0; req = 8'b1000_0100;
        do_reset();
        step();
        chk("prio_first", 32'(grant), 32'h04);
        done = 1'b1;
        step();
        step();
        chk("prio_second", 32'(grant), 32'h80);
        step();
        step();
        chk("prio_wrap", 32'(grant), 32'h04);

        // Request drop moves pointer past the owner
        done = 1'b0; req = 8'h08;
        do_reset();
        step();
        chk("drop_owner", 32'(grant), 32'h08);
        req = 8'h00;
        step();
        chk("drop_grant", 32'(grant), 32'h00);
        chk("drop_mux_en", 32'(mux_en), 32'h0);
        chk("drop_timeout", 32'(timeout), 32'h0);
        req = 8'hFF;
        step();
        chk("drop_ptr", 32'(grant), 32'h10);

        // Hold limit
        req = 8'h10;
        do_reset();
        step();
        cnt = 0;
        while (mux_en && cnt < 12) begin
            cnt++;
            step();
        end
`ifdef MUX_ARB_TIMEOUT_EN
        chk("hold_cycles", 32'(cnt), 32'(MAX_HOLD));
        chk("hold_timeout", 32'(timeout), 32'h1);
        step();
        chk("hold_regrant", 32'(grant), 32'h10);
        chk("hold_timeout_clr", 32'(timeout), 32'h0);
`else
        chk("hold_cycles", 32'(cnt), 32'd12);
        chk("hold_timeout", 32'(timeout), 32'h0);
`endif

        // Async reset mid-grant
        req = 8'h20;
        do_reset();
        step();
        chk("async_owner", 32'(grant), 32'h20);
        #1 rst = 1'b1; #1;
        chk("async_grant", 32'(grant), 32'h00);
        chk("async_mux_en", 32'(mux_en), 32'h0);
        rst = 1'b0; req = 8'hFF;
        step();
        chk("async_restart", 32'(grant), 32'h01);

        // Randomized traffic; the per-cycle compare process does the checking
        for (int n = 0; n < 500; n++) begin
            req  = 8'($urandom) & 8'($urandom) & 8'($urandom);
            if ($urandom_range(0, 3) == 0) req = 8'($urandom);
            done = ($urandom_range(0, 4) == 0);
            if ($urandom_range(0, 99) == 0) do_reset();
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/mux8x1_rr_arbiter.md
Name: mux8x1_rr_arbiter

Overview:
Round-robin arbiter that shares one 8x1 multiplexer (EN, 4-bit select A, 8 data inputs X, output Q) among 8 requesters.
- Drives the mux enable and select lines directly.
- Enforces break-before-make: mux enable is low for at least one cycle between successive owners.
- Sits between requesting agents and the mux instance.

Parameters:
N_REQ, 8, number of requesters; fixed to the mux input count.
SEL_W, 4, width of the mux select output; matches mux A port.
MAX_HOLD, 4, maximum consecutive grant cycles per owner; legal range 1..15 (timeout feature only).

Ports:
clk  input  1  clock; all state updates on rising edge.
rst  input  1  asynchronous, active-high reset.
req  input  8  request vector; bit i = requester i wants the mux.
done  input  1  current owner finished; sampled only in GRANT.
grant  output  8  one-hot grant to the current owner; all zero when no owner.
sel  output  SEL_W  mux select = index of the owner; upper bit always 0.
mux_en  output  1  mux enable; 1 only in GRANT.
busy  output  1  1 while a grant is held.
timeout  output  1  one-cycle pulse when a grant is forcibly revoked.

Behaviour:
Reset (async, rst=1):
- grant=0, sel=0, mux_en=0, busy=0, timeout=0.
- State=IDLE, hold_cnt=0, priority pointer ptr=0 (requester 0 highest).
- Asserting rst mid-grant drops mux_en and grant immediately, without waiting for a clock edge.

States:
- IDLE: mux_en=0, grant=0.
  - If req!=0 at a rising edge: pick the first set bit scanning ptr, ptr+1, ..., 7, 0, ... (mod 8).
  - Register that index into sel, set grant=1<<index, mux_en=1, busy=1, hold_cnt=0, and go to GRANT.
  - Latency: req asserted before edge k gives grant/mux_en visible after edge k (1 cycle).
  - If req=0: stay in IDLE; sel holds its last value.
- GRANT: outputs stable. At each edge, evaluate in this priority order:
  (a) req[sel]==0 -> release.
  (b) done==1 -> release.
  (c) timeout feature enabled and hold_cnt==MAX_HOLD-1 -> release with timeout=1 for the next cycle.
  (d) otherwise hold_cnt += 1 and stay in GRANT.
- On release:
  - Go to IDLE; grant=0, mux_en=0, busy=0.
  - ptr=(sel+1) mod 8, i.e. the releasing owner becomes lowest priority.
  - The sel value is retained.
- Break-before-make: a release edge always lands in IDLE, so mux_en=0 for at least one full cycle. The next grant can appear at the following edge.
- Simultaneous events: done and timeout in the same cycle counts as a normal release; timeout stays 0.
- Other requesters changing req during GRANT has no effect on the current owner.
- sel width rule: sel = {1'b0, index[2:0]}; sel must never exceed 7.
- Pointer wrap: ptr=7 followed by release of 7 gives ptr=0.
- Invariants:
  - grant is always zero or one-hot.
  - grant[sel]==mux_en whenever busy=1.

Optional Feature:
MUX_ARB_TIMEOUT_EN
- Defined: hold_cnt is implemented and release rule (c) is active. timeout pulses 1 cycle after a forced release. A grant lasts at most MAX_HOLD cycles.
- Undefined: there is no hold counter. A grant persists until req drops or done is asserted. timeout is tied to 0. MAX_HOLD is unused.

Test Plan:
1. Reset check: rst=1 with req=8'hFF -> grant=0, mux_en=0, sel=0, busy=0. Release rst; after 1 edge, grant=8'h01, sel=0, mux_en=1.
2. Round-robin rotation: req=8'hFF held, done pulsed each GRANT cycle -> owners in order 0,1,...,7,0. mux_en=0 for exactly one cycle between owners.
3. Priority after release: ptr=0, req=8'b1000_0100. Grant 2, then done -> next grant 7. Then release 7 with req still 8'b1000_0100 -> grant 2 (wrap).
4. Request drop: owner 3 holding; deassert req[3] -> next edge grant=0, mux_en=0, timeout=0, ptr=4.
5. Timeout (MUX_ARB_TIMEOUT_EN, MAX_HOLD=4): req=8'h10 held, done=0 -> mux_en high exactly 4 cycles, then timeout=1 for 1 cycle, mux_en=0. Re-grant to 4 on the following edge. Without the macro, mux_en stays high indefinitely.
6. Async reset mid-grant: owner 5 active; pulse rst between clock edges -> grant and mux_en drop to 0 immediately. After release, arbitration restarts from ptr=0.
